// File: rtl/mips_multicycle_controller.sv
// Multi-cycle control FSM for the simplified MIPS datapath. It sequences each instruction,
// drives every mux select and strobe, and guards memory accesses with a bounded-wait watchdog.
//
// Handshake: during FETCH, MEM_READ and MEM_WRITE the request (mem_read or mem_write) acts as
// "valid". mem_ready acts as "ready". The access completes in the one cycle where both are high.
// While mem_ready stays low, the request and address select hold steady.
module mips_multicycle_controller #(
  parameter int unsigned MEM_WAIT_MAX = 16
) (
  input  logic       clock,
  input  logic       reset,
  input  logic [5:0] opcode,
  input  logic       alu_zero,
  input  logic       mem_ready,
  output logic       pc_write,
  output logic [1:0] pc_src,
  output logic       ir_write,
  output logic       iord,
  output logic       mem_read,
  output logic       mem_write,
  output logic       reg_write,
  output logic       reg_dst,
  output logic       mem_to_reg,
  output logic       alu_src_a,
  output logic [1:0] alu_src_b,
  output logic [1:0] alu_op,
  output logic       retired,
  output logic       illegal_op,
  output logic       mem_timeout,
  output logic [3:0] state
);

  typedef enum logic [3:0] {
    S_FETCH     = 4'd0,
    S_DECODE    = 4'd1,
    S_MEM_ADDR  = 4'd2,
    S_MEM_READ  = 4'd3,
    S_MEM_WB    = 4'd4,
    S_MEM_WRITE = 4'd5,
    S_R_EXEC    = 4'd6,
    S_R_WB      = 4'd7,
    S_BRANCH    = 4'd8,
    S_JUMP      = 4'd9,
    S_I_EXEC    = 4'd10,
    S_I_WB      = 4'd11,
    S_HALT      = 4'd15
  } state_e;

  localparam logic [5:0] OP_R    = 6'h00;
  localparam logic [5:0] OP_LW   = 6'h23;
  localparam logic [5:0] OP_SW   = 6'h2B;
  localparam logic [5:0] OP_BEQ  = 6'h04;
  localparam logic [5:0] OP_ADDI = 6'h08;
  localparam logic [5:0] OP_J    = 6'h02;

  // The watchdog fires on the MEM_WAIT_MAX-th consecutive waiting cycle, i.e. when the
  // count of already-elapsed waits is one below the limit.
  localparam logic [7:0] WAIT_LIM = (MEM_WAIT_MAX == 0) ? 8'd0 : 8'(MEM_WAIT_MAX - 1);

  state_e     state_q, state_d;
  logic [7:0] wait_q, wait_d;
  logic       illegal_q, illegal_d;
  logic       timeout_q, timeout_d;
  logic       mem_state;

  always_ff @(posedge clock) begin
    if (!reset) begin
      state_q   <= S_FETCH;
      wait_q    <= 8'd0;
      illegal_q <= 1'b0;
      timeout_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      wait_q    <= wait_d;
      illegal_q <= illegal_d;
      timeout_q <= timeout_d;
    end
  end

  assign mem_state = (state_q == S_FETCH) || (state_q == S_MEM_READ) || (state_q == S_MEM_WRITE);

  always_comb begin
    state_d   = state_q;
    wait_d    = 8'd0;
    illegal_d = illegal_q;
    timeout_d = timeout_q;
    case (state_q)
      S_FETCH:     if (mem_ready) state_d = S_DECODE;
      S_DECODE: begin
        case (opcode)
          OP_LW, OP_SW: state_d = S_MEM_ADDR;
          OP_R:         state_d = S_R_EXEC;
          OP_BEQ:       state_d = S_BRANCH;
          OP_J:         state_d = S_JUMP;
          OP_ADDI:      state_d = S_I_EXEC;
          default: begin
            state_d   = S_HALT;
            illegal_d = 1'b1;
          end
        endcase
      end
      S_MEM_ADDR:  state_d = (opcode == OP_LW) ? S_MEM_READ : S_MEM_WRITE;
      S_MEM_READ:  if (mem_ready) state_d = S_MEM_WB;
      S_MEM_WB:    state_d = S_FETCH;
      S_MEM_WRITE: if (mem_ready) state_d = S_FETCH;
      S_R_EXEC:    state_d = S_R_WB;
      S_R_WB:      state_d = S_FETCH;
      S_BRANCH:    state_d = S_FETCH;
      S_JUMP:      state_d = S_FETCH;
      S_I_EXEC:    state_d = S_I_WB;
      S_I_WB:      state_d = S_FETCH;
      S_HALT:      state_d = S_HALT;
      default: begin
        state_d   = S_HALT;
        illegal_d = 1'b1;
      end
    endcase
    // A completing access (mem_ready=1) always wins over the watchdog.
    if (mem_state && !mem_ready) begin
      if ((MEM_WAIT_MAX != 0) && (wait_q == WAIT_LIM)) begin
        state_d   = S_HALT;
        timeout_d = 1'b1;
      end else begin
        wait_d = (wait_q == 8'hFF) ? wait_q : wait_q + 8'd1;
      end
    end
  end

  always_comb begin
    pc_write   = 1'b0;
    pc_src     = 2'd0;
    ir_write   = 1'b0;
    iord       = 1'b0;
    mem_read   = 1'b0;
    mem_write  = 1'b0;
    reg_write  = 1'b0;
    reg_dst    = 1'b0;
    mem_to_reg = 1'b0;
    alu_src_a  = 1'b0;
    alu_src_b  = 2'd0;
    alu_op     = 2'd0;
    retired    = 1'b0;
    case (state_q)
      S_FETCH: begin
        mem_read  = 1'b1;
        alu_src_b = 2'd1;
        ir_write  = mem_ready;
        pc_write  = mem_ready;
      end
      S_DECODE:   alu_src_b = 2'd3;
      S_MEM_ADDR: begin
        alu_src_a = 1'b1;
        alu_src_b = 2'd2;
      end
      S_MEM_READ: begin
        mem_read = 1'b1;
        iord     = 1'b1;
      end
      S_MEM_WB: begin
        reg_write  = 1'b1;
        mem_to_reg = 1'b1;
        retired    = 1'b1;
      end
      S_MEM_WRITE: begin
        mem_write = 1'b1;
        iord      = 1'b1;
        retired   = mem_ready;
      end
      S_R_EXEC: begin
        alu_src_a = 1'b1;
        alu_op    = 2'd2;
      end
      S_R_WB: begin
        reg_write = 1'b1;
        reg_dst   = 1'b1;
        retired   = 1'b1;
      end
      S_BRANCH: begin
        alu_src_a = 1'b1;
        alu_op    = 2'd1;
        pc_src    = 2'd1;
        pc_write  = alu_zero;
        retired   = 1'b1;
      end
      S_JUMP: begin
        pc_src   = 2'd2;
        pc_write = 1'b1;
        retired  = 1'b1;
      end
      S_I_EXEC: begin
        alu_src_a = 1'b1;
        alu_src_b = 2'd2;
      end
      S_I_WB: begin
        reg_write = 1'b1;
        retired   = 1'b1;
      end
      default: ;
    endcase
    // Holding reset low squashes every strobe, even when it arrives mid-instruction.
    if (!reset) begin
      pc_write  = 1'b0;
      ir_write  = 1'b0;
      mem_read  = 1'b0;
      mem_write = 1'b0;
      reg_write = 1'b0;
      retired   = 1'b0;
    end
  end

  assign illegal_op  = illegal_q;
  assign mem_timeout = timeout_q;
  assign state       = state_q;

endmodule

// File: tb/tb_mips_multicycle_controller.sv
// Bench for mips_multicycle_controller. It applies a table of zero-wait instructions, then
// hand-written reset, wait, timeout and illegal-opcode sequences, then random instruction streams.
// A per-instruction model predicts the outputs cycle by cycle.
module tb_mips_multicycle_controller;

  localparam int WMAX = 4;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic [5:0] opcode = 6'd0;
  logic       alu_zero = 1'b0;
  logic       mem_ready = 1'b0;
  logic       pc_write, ir_write, iord, mem_read, mem_write, reg_write;
  logic       reg_dst, mem_to_reg, alu_src_a, retired, illegal_op, mem_timeout;
  logic [1:0] pc_src, alu_src_b, alu_op;
  logic [3:0] state;

  mips_multicycle_controller #(.MEM_WAIT_MAX(WMAX)) dut (
    .clock(clk), .reset(reset), .opcode(opcode), .alu_zero(alu_zero), .mem_ready(mem_ready),
    .pc_write(pc_write), .pc_src(pc_src), .ir_write(ir_write), .iord(iord),
    .mem_read(mem_read), .mem_write(mem_write), .reg_write(reg_write), .reg_dst(reg_dst),
    .mem_to_reg(mem_to_reg), .alu_src_a(alu_src_a), .alu_src_b(alu_src_b), .alu_op(alu_op),
    .retired(retired), .illegal_op(illegal_op), .mem_timeout(mem_timeout), .state(state)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad = 0;
  int cyc = 0;
  logic ill_f = 1'b0;
  logic tmo_f = 1'b0;
  logic halted = 1'b0;
  logic [21:0] exp_q[$];
  logic [7:0]  stim_q[$];

  typedef struct {
    logic [5:0]  op;
    logic        z;
    int          n;
    logic [19:0] seq;
  } vec_t;
  vec_t vt[6];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s cyc=%0d: got=%0h expected=%0h", name, cyc, act, exp);
    end
  endtask

  function automatic logic [5:0] strobes();
    return {pc_write, ir_write, mem_read, mem_write, reg_write, retired};
  endfunction

  function automatic logic [21:0] act_vec();
    return {state, pc_write, pc_src, ir_write, iord, mem_read, mem_write, reg_write, reg_dst,
            mem_to_reg, alu_src_a, alu_src_b, alu_op, retired, illegal_op, mem_timeout};
  endfunction

  // Expected output record; the sticky flags come from the model's current fault state.
  function automatic logic [21:0] mk(input int st, input int pcw, input int pcs, input int irw,
                                     input int io, input int mr, input int mw, input int rw,
                                     input int rd, input int m2r, input int asa, input int asb,
                                     input int aop, input int ret);
    return {4'(st), 1'(pcw), 2'(pcs), 1'(irw), 1'(io), 1'(mr), 1'(mw), 1'(rw), 1'(rd),
            1'(m2r), 1'(asa), 2'(asb), 2'(aop), 1'(ret), ill_f, tmo_f};
  endfunction

  task automatic push(input logic [5:0] op, input logic z, input logic mr, input logic [21:0] rec);
    stim_q.push_back({op, z, mr});
    exp_q.push_back(rec);
  endtask

  task automatic push_halt();
    for (int i = 0; i < 3; i++)
      push(6'($urandom), 1'($urandom), 1'($urandom), mk(15, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    halted = 1'b1;
  endtask

  // One instruction: fw waiting cycles in FETCH, mw waiting cycles in its memory state.
  task automatic gen_instr(input logic [5:0] op, input logic z, input int fw, input int mw);
    logic is_lw;
    for (int i = 0; i < fw; i++) begin
      push(6'($urandom), z, 1'b0, mk(0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 1, 0, 0));
      if (i == WMAX - 1) begin
        tmo_f = 1'b1;
        push_halt();
        return;
      end
    end
    push(6'($urandom), z, 1'b1, mk(0, 1, 0, 1, 0, 1, 0, 0, 0, 0, 0, 1, 0, 0));
    push(op, z, 1'($urandom), mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 3, 0, 0));
    case (op)
      6'h00: begin
        push(op, z, 1'($urandom), mk(6, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 2, 0));
        push(op, z, 1'($urandom), mk(7, 0, 0, 0, 0, 0, 0, 1, 1, 0, 0, 0, 0, 1));
      end
      6'h08: begin
        push(op, z, 1'($urandom), mk(10, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 2, 0, 0));
        push(op, z, 1'($urandom), mk(11, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 1));
      end
      6'h04: push(op, z, 1'($urandom), mk(8, int'(z), 1, 0, 0, 0, 0, 0, 0, 0, 1, 0, 1, 1));
      6'h02: push(op, z, 1'($urandom), mk(9, 1, 2, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1));
      6'h23, 6'h2B: begin
        is_lw = (op == 6'h23);
        push(op, z, 1'($urandom), mk(2, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 2, 0, 0));
        for (int i = 0; i < mw; i++) begin
          if (is_lw) push(op, z, 1'b0, mk(3, 0, 0, 0, 1, 1, 0, 0, 0, 0, 0, 0, 0, 0));
          else       push(op, z, 1'b0, mk(5, 0, 0, 0, 1, 0, 1, 0, 0, 0, 0, 0, 0, 0));
          if (i == WMAX - 1) begin
            tmo_f = 1'b1;
            push_halt();
            return;
          end
        end
        if (is_lw) begin
          push(op, z, 1'b1, mk(3, 0, 0, 0, 1, 1, 0, 0, 0, 0, 0, 0, 0, 0));
          push(op, z, 1'($urandom), mk(4, 0, 0, 0, 0, 0, 0, 1, 0, 1, 0, 0, 0, 1));
        end else begin
          push(op, z, 1'b1, mk(5, 0, 0, 0, 1, 0, 1, 0, 0, 0, 0, 0, 0, 1));
        end
      end
      default: begin
        ill_f = 1'b1;
        push_halt();
      end
    endcase
  endtask

  // Entered and left at a falling edge: drive, settle, compare, advance one cycle.
  task automatic run_n(input int k);
    logic [7:0]  s;
    logic [21:0] e;
    for (int i = 0; i < k && stim_q.size() > 0; i++) begin
      s = stim_q.pop_front();
      e = exp_q.pop_front();
      {opcode, alu_zero, mem_ready} = s;
      #1 chk("ctrl_vec", 32'(act_vec()), 32'(e));
      cyc++;
      @(negedge clk);
    end
  endtask

  task automatic run_all();
    run_n(1000);
  endtask

  task automatic do_reset();
    reset = 1'b0;
    mem_ready = 1'($urandom);
    opcode = 6'($urandom);
    #1 chk("rst_strobes_first", 32'(strobes()), 32'd0);
    @(negedge clk);
    mem_ready = 1'b1;
    #1 chk("rst_strobes_held", 32'(strobes()), 32'd0);
    chk("rst_state", 32'(state), 32'd0);
    chk("rst_flags", 32'({illegal_op, mem_timeout}), 32'd0);
    @(negedge clk);
    reset = 1'b1;
    ill_f = 1'b0;
    tmo_f = 1'b0;
    halted = 1'b0;
    exp_q.delete();
    stim_q.delete();
  endtask

  initial begin
    int ret_cnt;
    int pcw_cnt;
    logic [5:0] ops[6];
    ops = '{6'h00, 6'h23, 6'h2B, 6'h04, 6'h02, 6'h08};
    vt[0] = '{op: 6'h00, z: 1'b1, n: 4, seq: 20'h01670};
    vt[1] = '{op: 6'h23, z: 1'b1, n: 5, seq: 20'h01234};
    vt[2] = '{op: 6'h2B, z: 1'b1, n: 4, seq: 20'h01250};
    vt[3] = '{op: 6'h04, z: 1'b1, n: 3, seq: 20'h01800};
    vt[4] = '{op: 6'h02, z: 1'b1, n: 3, seq: 20'h01900};
    vt[5] = '{op: 6'h08, z: 1'b1, n: 4, seq: 20'h01AB0};

    @(negedge clk);
    do_reset();

    // Zero-wait table: state sequence, single retire pulse, pc_write count.
    ret_cnt = 0;
    pcw_cnt = 0;
    for (int v = 0; v < 6; v++) begin
      for (int c = 0; c < vt[v].n; c++) begin
        opcode = vt[v].op;
        alu_zero = vt[v].z;
        mem_ready = 1'b1;
        #1 chk("tbl_state", 32'(state), 32'(vt[v].seq[19-4*c -: 4]));
        chk("tbl_retired", 32'(retired), 32'(c == vt[v].n - 1));
        ret_cnt += int'(retired);
        pcw_cnt += int'(pc_write);
        cyc++;
        @(negedge clk);
      end
    end
    chk("tbl_retire_count", 32'(ret_cnt), 32'd6);
    chk("tbl_pcwrite_count", 32'(pcw_cnt), 32'd8);

    // Reset in R_EXEC, then in R_WB where reg_write and retired must be squashed.
    gen_instr(6'h00, 1'b0, 0, 0);
    run_n(2);
    do_reset();
    gen_instr(6'h00, 1'b0, 0, 0);
    run_n(3);
    do_reset();

    // beq not taken, lw with three memory waits.
    gen_instr(6'h04, 1'b0, 0, 0);
    gen_instr(6'h23, 1'b0, 0, 3);
    run_all();

    // FETCH stuck: timeout on the 4th wait; then mem_ready on the 4th cycle rescues it.
    gen_instr(6'h00, 1'b0, WMAX, 0);
    run_all();
    do_reset();
    gen_instr(6'h00, 1'b0, WMAX - 1, 0);
    run_all();

    // Illegal opcode halts with a sticky flag; reset clears it.
    gen_instr(6'h3F, 1'b0, 0, 0);
    run_all();
    do_reset();

    // Random instruction stream with random waits and occasional illegal opcodes.
    for (int i = 0; i < 60; i++) begin
      logic [5:0] op;
      int fw;
      int mw;
      op = ($urandom_range(0, 15) == 0) ? 6'h3F : ops[$urandom_range(0, 5)];
      fw = ($urandom_range(0, 5) == 0) ? int'($urandom_range(0, 5)) : 0;
      mw = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 5)) : 0;
      gen_instr(op, 1'($urandom), fw, mw);
      run_all();
      if (halted) do_reset();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/mips_multicycle_controller.md
Name: mips_multicycle_controller

Overview:
- Multi-cycle control FSM for the simplified MIPS CPU datapath (PC, IR, register file, ALU, ALUOut, unified memory).
- Sequences each instruction through fetch/decode/execute/memory/writeback and drives every datapath mux select and write strobe.
- Owns the unified-memory handshake with a bounded-wait watchdog.
- Raises sticky fault flags and halts on an illegal opcode or a memory timeout.

Parameters:
- MEM_WAIT_MAX, 16: maximum consecutive cycles a memory state may wait for mem_ready before a timeout fault. 0 disables the watchdog. Legal range 0..255.

Ports:
- clock  in  1  system clock; all state updates on the rising edge.
- reset  in  1  synchronous, active-low reset.
- opcode  in  6  IR[31:26]; valid from DECODE onward.
- alu_zero  in  1  ALU zero flag.
- mem_ready  in  1  memory completes the current access this cycle.
- pc_write  out  1  load PC.
- pc_src  out  2  PC source: 0 = ALU result, 1 = ALUOut (branch target), 2 = jump target.
- ir_write  out  1  load IR.
- iord  out  1  memory address: 0 = PC, 1 = ALUOut.
- mem_read  out  1  memory read request.
- mem_write  out  1  memory write request.
- reg_write  out  1  register file write.
- reg_dst  out  1  destination register: 0 = rt, 1 = rd.
- mem_to_reg  out  1  write data: 0 = ALUOut, 1 = MDR.
- alu_src_a  out  1  ALU A input: 0 = PC, 1 = register A.
- alu_src_b  out  2  ALU B input: 0 = register B, 1 = constant 4, 2 = sign-extended immediate, 3 = sign-extended immediate << 2.
- alu_op  out  2  0 = add, 1 = sub, 2 = decode funct.
- retired  out  1  one-cycle pulse on an instruction's final cycle.
- illegal_op  out  1  sticky illegal-opcode fault.
- mem_timeout  out  1  sticky memory-watchdog fault.
- state  out  4  current state encoding, for debug and the bench.

Behaviour:
- Reset: when reset=0 at a rising edge:
  - state <= FETCH (0), wait counter <= 0, illegal_op <= 0, mem_timeout <= 0.
  - While reset=0, all strobes (pc_write, ir_write, mem_read, mem_write, reg_write, retired) are forced to 0 combinationally.
  - Reset mid-instruction abandons it; no strobe fires in that cycle.
- Outputs are a combinational function of state, gated by mem_ready and alu_zero where noted. Any select not listed for a state is 0.
- Supported opcodes: R-type 0x00, lw 0x23, sw 0x2B, beq 0x04, addi 0x08, j 0x02.
- FETCH(0):
  - mem_read=1, iord=0, alu_src_a=0, alu_src_b=1, alu_op=0, pc_src=0.
  - ir_write=pc_write=mem_ready.
  - Stay while mem_ready=0; go to DECODE when mem_ready=1.
- DECODE(1):
  - alu_src_a=0, alu_src_b=3, alu_op=0 (branch target into ALUOut).
  - Next state: lw/sw -> MEM_ADDR, R-type -> R_EXEC, beq -> BRANCH, j -> JUMP, addi -> I_EXEC, any other opcode -> HALT with illegal_op <= 1.
- MEM_ADDR(2): alu_src_a=1, alu_src_b=2, alu_op=0. Go to MEM_READ if lw, MEM_WRITE if sw.
- MEM_READ(3): mem_read=1, iord=1. Wait for mem_ready, then MEM_WB.
- MEM_WB(4): reg_write=1, reg_dst=0, mem_to_reg=1, retired=1. Go to FETCH.
- MEM_WRITE(5): mem_write=1, iord=1. Wait for mem_ready; in the mem_ready cycle retired=1, then FETCH.
- R_EXEC(6): alu_src_a=1, alu_src_b=0, alu_op=2. Go to R_WB.
- R_WB(7): reg_write=1, reg_dst=1, mem_to_reg=0, retired=1. Go to FETCH.
- BRANCH(8):
  - alu_src_a=1, alu_src_b=0, alu_op=1, pc_src=1.
  - pc_write=alu_zero, retired=1. Go to FETCH.
- JUMP(9): pc_src=2, pc_write=1, retired=1. Go to FETCH.
- I_EXEC(10): alu_src_a=1, alu_src_b=2, alu_op=0. Go to I_WB.
- I_WB(11): reg_write=1, reg_dst=0, mem_to_reg=0, retired=1. Go to FETCH.
- HALT(15): all strobes 0. Stays in HALT until reset.
- Zero-wait latency in cycles: R-type 4, lw 5, sw 4, addi 4, beq 3, j 3.
- Each mem_ready=0 cycle in a memory state adds one cycle.
- Watchdog:
  - The 8-bit wait counter increments each cycle a memory state (FETCH, MEM_READ, MEM_WRITE) holds with mem_ready=0.
  - It clears on leaving that state or on mem_ready=1.
  - If MEM_WAIT_MAX≠0 and the counter reaches MEM_WAIT_MAX with mem_ready still 0, the next state is HALT and mem_timeout <= 1.
  - mem_ready=1 in the same cycle the limit is reached wins: the access completes normally.
- mem_ready outside a memory state is ignored.
- Unused states 12–14 go to HALT with illegal_op <= 1.

Test Plan:
- Reset held low for 2 edges mid-R_EXEC, then released -> state=0, all strobes 0 during reset, fault flags 0, FETCH on the first cycle after release.
- mem_ready tied to 1, sequence add, lw, sw, beq (alu_zero=1), j, addi -> states 0,1,6,7 / 0,1,2,3,4 / 0,1,2,5 / 0,1,8 / 0,1,9 / 0,1,10,11.
  - retired pulses exactly 6 times.
  - pc_write fires in each FETCH and in the BRANCH and JUMP cycles.
- beq with alu_zero=0 -> pc_write=0 in BRANCH, retired=1, next state FETCH.
- lw with mem_ready low for 3 cycles in MEM_READ -> MEM_READ held 4 cycles, reg_write=1 only in MEM_WB, lw total 8 cycles.
- MEM_WAIT_MAX=4 with mem_ready stuck at 0 in FETCH -> HALT after 4 wait cycles, mem_timeout=1, no further strobes. A second run with mem_ready=1 on the 4th wait cycle -> normal DECODE, no fault.
- opcode 0x3F at DECODE -> HALT (15), illegal_op=1 sticky; reset clears it.
